// File: rtl/dt_pkg.sv
// Shared FSM state encodings and error codes for the decision-tree traversal engine.
package dt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DEPTH   = 2'd1;
  localparam logic [1:0] ERR_FIDX    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/dt_split_compare.sv
// Selects the split feature named by a node and compares it (signed) against the node threshold.
module dt_split_compare
  import dt_pkg::*;
#(
  parameter int NUM_FEATURES = 4,
  parameter int FEAT_W       = 64,
  parameter int FIDX_W       = 2
) (
  input  logic [NUM_FEATURES*FEAT_W-1:0] features,
  input  logic [FIDX_W-1:0]              feature_idx,
  input  logic [FEAT_W-1:0]              threshold,
  output logic                           idx_valid,
  output logic                           go_left
);

  logic signed [FEAT_W-1:0] feat_sel;
  logic signed [FEAT_W-1:0] thr_s;

  // An index with no matching feature leaves idx_valid low; the engine faults on it.
  always_comb begin
    feat_sel  = '0;
    idx_valid = 1'b0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (feature_idx == FIDX_W'(i)) begin
        feat_sel  = features[i*FEAT_W +: FEAT_W];
        idx_valid = 1'b1;
      end
    end
    thr_s   = threshold;
    go_left = (feat_sel <= thr_s);
  end

endmodule

// File: rtl/dt_traversal_engine.sv
// Decision-tree inference engine: walks nodes from an external node memory until a leaf or fault.
// Optional macro DT_MEM_TIMEOUT_EN bounds the wait for a node memory response.
module dt_traversal_engine
  import dt_pkg::*;
#(
  parameter int NUM_FEATURES   = 4,
  parameter int FEAT_W         = 64,
  parameter int NODE_AW        = 9,
  parameter int CLASS_W        = 2,
  parameter int MAX_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int FIDX_W        = (NUM_FEATURES > 2) ? $clog2(NUM_FEATURES) : 1,
  localparam int DEPTH_W       = $clog2(MAX_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_FEATURES*FEAT_W-1:0] features,
  input  logic [NODE_AW-1:0]             root_addr,
  output logic                           busy,
  output logic                           done,
  output logic [CLASS_W-1:0]             result,
  output logic                           is_attack,
  output logic [NODE_AW-1:0]             final_node,
  output logic [DEPTH_W-1:0]             depth,
  output logic                           err,
  output logic [1:0]                     err_code,
  output logic                           mem_req,
  output logic [NODE_AW-1:0]             mem_addr,
  input  logic                           mem_rvalid,
  input  logic [FIDX_W-1:0]              mem_feature_idx,
  input  logic [FEAT_W-1:0]              mem_threshold,
  input  logic [NODE_AW-1:0]             mem_left,
  input  logic [NODE_AW-1:0]             mem_right,
  input  logic [CLASS_W-1:0]             mem_prediction,
  input  logic                           mem_is_leaf
);

  if (NUM_FEATURES < 2 || MAX_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dt_traversal_engine: illegal parameter value");
  end

  state_e                         state_q, state_d;
  logic [NODE_AW-1:0]             cur_node_q, cur_node_d;
  logic [CLASS_W-1:0]             result_q, result_d;
  logic                           is_attack_q, is_attack_d;
  logic [NODE_AW-1:0]             final_node_q, final_node_d;
  logic [DEPTH_W-1:0]             depth_q, depth_d;
  logic                           err_q, err_d;
  logic [1:0]                     err_code_q, err_code_d;
  logic [NUM_FEATURES*FEAT_W-1:0] feat_q, feat_d;
  logic [FIDX_W-1:0]              fidx_q, fidx_d;
  logic [FEAT_W-1:0]              thr_q, thr_d;
  logic [NODE_AW-1:0]             left_q, left_d, right_q, right_d;
  logic [CLASS_W-1:0]             pred_q, pred_d;
  logic                           leaf_q, leaf_d;
  logic                           fault;
  logic [1:0]                     fault_code;
  logic                           idx_valid, go_left;
`ifdef DT_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]               tmo_cnt_q, tmo_cnt_d;
`endif

  dt_split_compare #(
    .NUM_FEATURES (NUM_FEATURES),
    .FEAT_W       (FEAT_W),
    .FIDX_W       (FIDX_W)
  ) u_split (
    .features    (feat_q),
    .feature_idx (fidx_q),
    .threshold   (thr_q),
    .idx_valid   (idx_valid),
    .go_left     (go_left)
  );

  always_comb begin
    state_d      = state_q;
    cur_node_d   = cur_node_q;
    result_d     = result_q;
    is_attack_d  = is_attack_q;
    final_node_d = final_node_q;
    depth_d      = depth_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    feat_d       = feat_q;
    fidx_d       = fidx_q;
    thr_d        = thr_q;
    left_d       = left_q;
    right_d      = right_q;
    pred_d       = pred_q;
    leaf_d       = leaf_q;
    fault        = 1'b0;
    fault_code   = ERR_NONE;
    mem_req      = 1'b0;
`ifdef DT_MEM_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          feat_d     = features;
          cur_node_d = root_addr;
          depth_d    = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        state_d = ST_WAIT;
`ifdef DT_MEM_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_EVAL;
          fidx_d  = mem_feature_idx;
          thr_d   = mem_threshold;
          left_d  = mem_left;
          right_d = mem_right;
          pred_d  = mem_prediction;
          leaf_d  = mem_is_leaf;
        end
`ifdef DT_MEM_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          fault      = 1'b1;
          fault_code = ERR_TIMEOUT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_EVAL: begin
        // Leaves ignore the feature index; depth is checked before the index on internal nodes.
        if (leaf_q) begin
          state_d      = ST_DONE;
          result_d     = pred_q;
          is_attack_d  = |pred_q;
          final_node_d = cur_node_q;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          fault      = 1'b1;
          fault_code = ERR_DEPTH;
        end else if (!idx_valid) begin
          fault      = 1'b1;
          fault_code = ERR_FIDX;
        end else begin
          state_d    = ST_FETCH;
          cur_node_d = go_left ? left_q : right_q;
          depth_d    = depth_q + 1'b1;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
    if (fault) begin
      state_d      = ST_ERR;
      err_d        = 1'b1;
      err_code_d   = fault_code;
      result_d     = '0;
      is_attack_d  = 1'b0;
      final_node_d = cur_node_q;
    end
  end

  // rst_n is an active-high asynchronous reset in this codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      cur_node_q   <= '0;
      result_q     <= '0;
      is_attack_q  <= 1'b0;
      final_node_q <= '0;
      depth_q      <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
`ifdef DT_MEM_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_node_q   <= cur_node_d;
      result_q     <= result_d;
      is_attack_q  <= is_attack_d;
      final_node_q <= final_node_d;
      depth_q      <= depth_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
`ifdef DT_MEM_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    feat_q  <= feat_d;
    fidx_q  <= fidx_d;
    thr_q   <= thr_d;
    left_q  <= left_d;
    right_q <= right_d;
    pred_q  <= pred_d;
    leaf_q  <= leaf_d;
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign mem_addr   = cur_node_q;
  assign result     = result_q;
  assign is_attack  = is_attack_q;
  assign final_node = final_node_q;
  assign depth      = depth_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_dt_traversal_engine.sv
// Bench for dt_traversal_engine: tree walked by a behavioural model, node memory emulated with 1-cycle latency.
module tb_dt_traversal_engine;

  localparam int NF = 3;
  localparam int FW = 64;
  localparam int AW = 9;
  localparam int CW = 2;
  localparam int MD = 4;
  localparam int TO = 8;
  localparam int XW = 2;
  localparam int DW = 3;

  logic               clk = 1'b0;
  logic               rst_n, start;
  logic [NF*FW-1:0]   features;
  logic [AW-1:0]      root_addr;
  logic               busy, done, is_attack, err, mem_req;
  logic [CW-1:0]      result;
  logic [AW-1:0]      final_node, mem_addr;
  logic [DW-1:0]      depth;
  logic [1:0]         err_code;
  logic               mem_rvalid, mem_is_leaf;
  logic [XW-1:0]      mem_feature_idx;
  logic [FW-1:0]      mem_threshold;
  logic [AW-1:0]      mem_left, mem_right;
  logic [CW-1:0]      mem_prediction;

  dt_traversal_engine #(
    .NUM_FEATURES(NF), .FEAT_W(FW), .NODE_AW(AW), .CLASS_W(CW),
    .MAX_DEPTH(MD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .features(features), .root_addr(root_addr),
    .busy(busy), .done(done), .result(result), .is_attack(is_attack), .final_node(final_node),
    .depth(depth), .err(err), .err_code(err_code), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_feature_idx(mem_feature_idx), .mem_threshold(mem_threshold),
    .mem_left(mem_left), .mem_right(mem_right), .mem_prediction(mem_prediction),
    .mem_is_leaf(mem_is_leaf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [XW-1:0]        t_idx  [512];
  logic signed [FW-1:0] t_thr  [512];
  logic [AW-1:0]        t_l    [512];
  logic [AW-1:0]        t_r    [512];
  logic [CW-1:0]        t_pred [512];
  logic                 t_leaf [512];
  logic signed [FW-1:0] feat_arr [NF];
  logic [AW-1:0]        exp_path [$];

  logic          withhold = 1'b0;
  logic          force_rv = 1'b0;
  int            m_n, m_dep;
  logic [CW-1:0] m_res;
  logic [AW-1:0] m_fin;
  logic          m_err;
  logic [1:0]    m_code;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic set_node(input int a, input int idx, input longint thr, input int l, input int r);
    t_idx[a] = XW'(idx); t_thr[a] = thr; t_l[a] = AW'(l); t_r[a] = AW'(r);
    t_pred[a] = '0; t_leaf[a] = 1'b0;
  endtask

  task automatic set_leaf(input int a, input int cls, input int idx);
    t_idx[a] = XW'(idx); t_thr[a] = '0; t_l[a] = '0; t_r[a] = '0;
    t_pred[a] = CW'(cls); t_leaf[a] = 1'b1;
  endtask

  // Tree walk straight from the traversal rules; also records the expected fetch sequence.
  task automatic model(input logic [AW-1:0] root);
    logic [AW-1:0] a;
    a = root; m_n = 0; m_dep = 0; m_err = 0; m_code = 0; m_res = 0; m_fin = 0;
    exp_path.delete();
    for (int k = 0; k < 64; k++) begin
      m_n++;
      exp_path.push_back(a);
      if (t_leaf[a]) begin m_res = t_pred[a]; m_fin = a; return; end
      if (m_dep == MD) begin m_err = 1; m_code = 1; m_fin = a; return; end
      if (int'(t_idx[a]) >= NF) begin m_err = 1; m_code = 2; m_fin = a; return; end
      a = (feat_arr[t_idx[a]] <= t_thr[a]) ? t_l[a] : t_r[a];
      m_dep++;
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NF; i++) features[i*FW +: FW] = feat_arr[i];
  endtask

  task automatic check_outs(input string nm);
    chk({nm, "_result"}, result, m_res);
    chk({nm, "_is_attack"}, is_attack, m_res != 0);
    chk({nm, "_final_node"}, final_node, m_fin);
    chk({nm, "_depth"}, depth, m_dep);
    chk({nm, "_err"}, err, m_err);
    chk({nm, "_err_code"}, err_code, m_code);
  endtask

  // Single compare process for one inference: busy each cycle, done latency 3L+1, outputs at done and after.
  task automatic run(input string nm, input logic [AW-1:0] root, input bit poke);
    bit seen;
    model(root);
    @(negedge clk);
    pack();
    root_addr = root;
    start = 1'b1;
    seen = 0;
    for (int cyc = 1; cyc <= 3*m_n + 10 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1;
        chk({nm, "_done_cycle"}, cyc, 3*m_n + 1);
        check_outs(nm);
        if (poke) start = 1'b1;
      end else begin
        chk({nm, "_busy"}, busy, 1'b1);
      end
    end
    if (!seen) chk({nm, "_done_seen"}, seen, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_idle_busy"}, busy, 1'b0);
      chk({nm, "_idle_done"}, done, 1'b0);
    end
    check_outs({nm, "_hold"});
  endtask

  // Node memory: responds one cycle after each request and checks the fetched address.
  initial begin
    logic          pending;
    logic [AW-1:0] pend_addr;
    pending = 0; pend_addr = '0;
    mem_rvalid = 0; mem_feature_idx = '0; mem_threshold = '0;
    mem_left = '0; mem_right = '0; mem_prediction = '0; mem_is_leaf = 0;
    forever begin
      @(negedge clk);
      mem_rvalid      = pending || force_rv;
      mem_feature_idx = pending ? t_idx[pend_addr] : '0;
      mem_threshold   = pending ? t_thr[pend_addr] : '0;
      mem_left        = pending ? t_l[pend_addr] : '0;
      mem_right       = pending ? t_r[pend_addr] : '0;
      mem_prediction  = pending ? t_pred[pend_addr] : '0;
      mem_is_leaf     = pending ? t_leaf[pend_addr] : 1'b0;
      pending = 0;
      if (mem_req) begin
        chk("fetch_expected", exp_path.size() != 0, 1'b1);
        if (exp_path.size() != 0) chk("fetch_addr", mem_addr, exp_path.pop_front());
        pending   = !withhold;
        pend_addr = mem_addr;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) set_leaf(a, 0, 0);
    set_node(0, 0, 100, 1, 2);  set_leaf(1, 0, 0);  set_leaf(2, 1, 0);
    set_node(10, 0, 0, 11, 12); set_leaf(11, 2, 0); set_leaf(12, 3, 0);
    set_node(20, 2, -5, 21, 22); set_leaf(21, 1, 0); set_leaf(22, 0, 0);
    for (int a = 100; a < 105; a++) set_node(a, 1, 0, a + 1, a + 1);
    set_leaf(105, 3, 0);
    set_node(30, 3, 0, 1, 2);   set_leaf(31, 2, 3);

    rst_n = 1'b1; start = 1'b0; features = '0; root_addr = '0;
    for (int i = 0; i < NF; i++) feat_arr[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_outs", {result, is_attack, final_node, depth, err, err_code}, '0);
    rst_n = 1'b0;

    feat_arr[0] = 50;
    run("f0_50", 0, 0);
    chk("pin_f0_50_cycle", 3*m_n + 1, 7);
    chk("pin_f0_50_final", m_fin, 1);
    feat_arr[0] = 200;
    run("f0_200", 0, 0);
    chk("pin_f0_200_result", m_res, 1);
    chk("pin_f0_200_final", m_fin, 2);
    feat_arr[0] = 100;
    run("f0_eq", 0, 1);
    chk("pin_f0_eq_final", m_fin, 1);
    feat_arr[0] = -1;
    run("signed", 10, 0);
    chk("pin_signed_final", m_fin, 11);
    feat_arr[0] = 1000; feat_arr[1] = 1000; feat_arr[2] = -10;
    run("fsel_left", 20, 0);
    chk("pin_fsel_left_final", m_fin, 21);
    feat_arr[2] = 7;
    run("fsel_right", 20, 0);

    feat_arr[1] = -3;
    run("chain_max", 101, 0);
    chk("pin_chain_max_depth", m_dep, MD);
    run("chain_over", 100, 0);
    chk("pin_chain_over_code", m_code, 1);
    chk("pin_chain_over_final", m_fin, 104);

    run("bad_idx", 30, 0);
    chk("pin_bad_idx_code", m_code, 2);
    run("leaf_idx", 31, 0);
    run("bad_idx2", 30, 0);
    feat_arr[0] = 200;
    run("clear_err", 0, 0);

`ifdef DT_MEM_TIMEOUT_EN
    begin
      bit seen;
      withhold = 1'b1;
      exp_path.delete(); exp_path.push_back(0);
      @(negedge clk); pack(); root_addr = 0; start = 1'b1;
      seen = 0;
      for (int cyc = 1; cyc <= TO + 10 && !seen; cyc++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) begin
          seen = 1;
          chk("tmo_done_cycle", cyc, TO + 2);
          chk("tmo_err_code", err_code, 2'd3);
          chk("tmo_err", err, 1'b1);
          chk("tmo_final", final_node, 0);
          chk("tmo_result", result, 0);
        end
      end
      if (!seen) chk("tmo_done_seen", seen, 1'b1);
      withhold = 1'b0;
      @(negedge clk);
      run("after_tmo", 0, 0);
    end
`endif

    withhold = 1'b1;
    exp_path.delete(); exp_path.push_back(0);
    @(negedge clk); pack(); root_addr = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_result", result, 1);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_outs", {done, result, is_attack, final_node, depth, err, err_code}, '0);
    @(negedge clk);
    rst_n = 1'b0; withhold = 1'b0; force_rv = 1'b1;
    repeat (2) @(negedge clk);
    force_rv = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_rv_busy", busy, 1'b0);
    chk("late_rv_done", done, 1'b0);
    chk("late_rv_outs", {result, is_attack, final_node, depth, err, err_code}, '0);
    feat_arr[0] = 50;
    run("post_rst", 0, 0);
    chk("extra_fetches", exp_path.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
